// File: rtl/hazard_stall_ctrl_if.sv
// Decode-stage hazard bus between the D stage and the hazard/stall controller.
// The pipeline is master: it presents the D-stage operand info and consumes the stall controls.
interface hazard_stall_ctrl_if;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_Tuse_rs;
  logic [1:0] D_Tuse_rt;
  logic [4:0] D_GRF_A3;
  logic       D_GRFWE;
  logic [1:0] D_Tnew;
  logic [1:0] D_MDStart;
  logic       D_MDUse;
  logic       STALL;
  logic       STALL_RESET;
  logic       MD_BUSY;

  modport master (
    output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_GRF_A3, D_GRFWE, D_Tnew, D_MDStart, D_MDUse,
    input  STALL, STALL_RESET, MD_BUSY
  );

  modport slave (
    input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_GRF_A3, D_GRFWE, D_Tnew, D_MDStart, D_MDUse,
    output STALL, STALL_RESET, MD_BUSY
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: mirrors the E/M destinations with
// their Tnew, compares them against D-stage Tuse, and holds MDU users while the MDU is busy.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               RESET,
  hazard_stall_ctrl_if.slave hz
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [4:0] e_a3_r;
  logic       e_we_r;
  logic [1:0] e_tnew_r;
  logic [4:0] m_a3_r;
  logic       m_we_r;
  logic [1:0] m_tnew_r;
  logic [3:0] md_cnt_r;
  logic       start_in_e_r;
  logic       start_div_r;

  logic       haz_rs_s;
  logic       haz_rt_s;
  logic       md_busy_s;
  logic       md_stall_s;
  logic       md_start_s;
  logic       stall_s;

  // A source hazards against one stage only if the value arrives later than it is consumed.
  // Tuse=3 (unused) can never be below a Tnew of at most 2, and $0 is never a dependency.
  function automatic logic src_haz(input logic [4:0] r, input logic [1:0] tu,
                                   input logic [4:0] a3, input logic we, input logic [1:0] tnew);
    return (r != 5'd0) && we && (a3 == r) && (tu < tnew);
  endfunction

  // Stall decision, purely combinational from mirrored state and the D-stage fields.
  always_comb begin
    haz_rs_s   = 1'b0;
    haz_rt_s   = 1'b0;
    md_busy_s  = 1'b0;
    md_stall_s = 1'b0;
    md_start_s = 1'b0;
    stall_s    = 1'b0;
    haz_rs_s   = src_haz(hz.D_rs, hz.D_Tuse_rs, e_a3_r, e_we_r, e_tnew_r)
               | src_haz(hz.D_rs, hz.D_Tuse_rs, m_a3_r, m_we_r, m_tnew_r);
    haz_rt_s   = src_haz(hz.D_rt, hz.D_Tuse_rt, e_a3_r, e_we_r, e_tnew_r)
               | src_haz(hz.D_rt, hz.D_Tuse_rt, m_a3_r, m_we_r, m_tnew_r);
    md_busy_s  = (md_cnt_r != 4'd0);
    if (hz.D_MDUse) begin
      md_stall_s = md_busy_s | start_in_e_r;
    end else begin
      md_stall_s = 1'b0;
    end
    case (hz.D_MDStart)
      2'b01:   md_start_s = 1'b1;
      2'b10:   md_start_s = 1'b1;
      default: md_start_s = 1'b0;
    endcase
    stall_s = haz_rs_s | haz_rt_s | md_stall_s;
  end

  // Pipeline mirror of E/M and the MDU busy counter; RESET overrides everything.
  always_ff @(posedge clk) begin
    if (RESET) begin
      e_a3_r       <= 5'd0;
      e_we_r       <= 1'b0;
      e_tnew_r     <= 2'd0;
      m_a3_r       <= 5'd0;
      m_we_r       <= 1'b0;
      m_tnew_r     <= 2'd0;
      md_cnt_r     <= 4'd0;
      start_in_e_r <= 1'b0;
      start_div_r  <= 1'b0;
    end else begin
      if (stall_s) begin
        e_a3_r   <= 5'd0;
        e_we_r   <= 1'b0;
        e_tnew_r <= 2'd0;
      end else begin
        e_a3_r   <= hz.D_GRF_A3;
        e_we_r   <= hz.D_GRFWE;
        e_tnew_r <= hz.D_Tnew;
      end
      m_a3_r   <= e_a3_r;
      m_we_r   <= e_we_r;
      m_tnew_r <= (e_tnew_r == 2'd0) ? 2'd0 : (e_tnew_r - 2'd1);
      start_in_e_r <= md_start_s & ~stall_s;
      start_div_r  <= (hz.D_MDStart == 2'b10);
      // The busy time starts counting the cycle after the start instruction sits in E.
      if (start_in_e_r) begin
        md_cnt_r <= start_div_r ? DIV_LOAD : MULT_LOAD;
      end else if (md_cnt_r != 4'd0) begin
        md_cnt_r <= md_cnt_r - 4'd1;
      end else begin
        md_cnt_r <= 4'd0;
      end
    end
  end

  assign hz.STALL       = stall_s;
  assign hz.STALL_RESET = stall_s;
  assign hz.MD_BUSY     = md_busy_s;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a model built on absolute ready times and MDU busy windows.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic RESET = 1'b1;
  int   total = 0;
  int   bad = 0;

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .RESET (RESET),
    .hz    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each instruction that has entered E is kept with the absolute cycle at which its result
  // becomes forwardable; only the two most recent (E and M) matter.
  typedef struct {
    logic [4:0] dest;
    logic       we;
    int         ready;
  } ent_t;

  ent_t q[$];
  int   now = 0;
  int   md_e = -1000;
  int   md_end = -1000;
  bit   model_ok = 1'b0;

  function automatic bit reg_haz(input logic [4:0] r, input logic [1:0] tu);
    bit h = 1'b0;
    foreach (q[i]) begin
      if (r != 5'd0 && q[i].we && q[i].dest == r && int'(tu) < (q[i].ready - now)) h = 1'b1;
    end
    return h;
  endfunction

  initial begin
    forever begin
      bit   exp_stall;
      bit   exp_busy;
      bit   exp_md;
      ent_t e;
      @(negedge clk);
      exp_busy  = (md_e < now) && (now <= md_end);
      exp_md    = bus.D_MDUse && (md_e <= now) && (now <= md_end);
      exp_stall = reg_haz(bus.D_rs, bus.D_Tuse_rs) || reg_haz(bus.D_rt, bus.D_Tuse_rt) || exp_md;
      if (model_ok) begin
        check("model_stall", int'(bus.STALL), int'(exp_stall));
        check("model_stall_reset", int'(bus.STALL_RESET), int'(exp_stall));
        check("model_md_busy", int'(bus.MD_BUSY), int'(exp_busy));
      end
      if (RESET) begin
        q.delete();
        md_e = -1000;
        md_end = -1000;
        model_ok = 1'b1;
      end else if (model_ok) begin
        if (exp_stall) begin
          e.dest = 5'd0; e.we = 1'b0; e.ready = 0;
        end else begin
          e.dest = bus.D_GRF_A3; e.we = bus.D_GRFWE; e.ready = now + 1 + int'(bus.D_Tnew);
          if (bus.D_MDStart == 2'b01) begin
            md_e = now + 1; md_end = now + 1 + 5;
          end else if (bus.D_MDStart == 2'b10) begin
            md_e = now + 1; md_end = now + 1 + 10;
          end
        end
        q.push_front(e);
        while (q.size() > 2) void'(q.pop_back());
      end
      now++;
    end
  end

  // ---------------- stimulus ----------------
  // Drives one cycle of D-stage fields just after the edge and returns at the following negedge.
  task automatic issue(input logic rst,
                       input logic [4:0] rs, input logic [1:0] tu_rs,
                       input logic [4:0] rt, input logic [1:0] tu_rt,
                       input logic [4:0] a3, input logic we, input logic [1:0] tnew,
                       input logic [1:0] mds, input logic mdu);
    @(posedge clk);
    #1;
    RESET         = rst;
    bus.D_rs      = rs;
    bus.D_Tuse_rs = tu_rs;
    bus.D_rt      = rt;
    bus.D_Tuse_rt = tu_rt;
    bus.D_GRF_A3  = a3;
    bus.D_GRFWE   = we;
    bus.D_Tnew    = tnew;
    bus.D_MDStart = mds;
    bus.D_MDUse   = mdu;
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 2'b00, 1'b0);
  endtask

  initial begin
    int n_stall;
    int n_busy;
    int k;
    bit prev_stall;
    logic [4:0] rs, rt, a3;
    logic [1:0] tr, tt, tn, mds;
    logic we, mdu;

    bus.D_rs = 5'd0; bus.D_Tuse_rs = 2'd3; bus.D_rt = 5'd0; bus.D_Tuse_rt = 2'd3;
    bus.D_GRF_A3 = 5'd0; bus.D_GRFWE = 1'b0; bus.D_Tnew = 2'd0;
    bus.D_MDStart = 2'b00; bus.D_MDUse = 1'b0;

    issue(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 2'b00, 1'b0);
    issue(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 2'b00, 1'b0);
    nop(1);
    check("reset_stall", int'(bus.STALL), 0);
    check("reset_stall_reset", int'(bus.STALL_RESET), 0);
    check("reset_md_busy", int'(bus.MD_BUSY), 0);

    // Load-use: lw $8 (Tnew=2) then addu reading $8 at Tuse=1
    issue(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 1'b1, 2'd2, 2'b00, 1'b0);
    issue(1'b0, 5'd8, 2'd1, 5'd0, 2'd3, 5'd9, 1'b1, 2'd1, 2'b00, 1'b0);
    check("load_use_stall", int'(bus.STALL), 1);
    issue(1'b0, 5'd8, 2'd1, 5'd0, 2'd3, 5'd9, 1'b1, 2'd1, 2'b00, 1'b0);
    check("load_use_release", int'(bus.STALL), 0);
    nop(3);

    // ALU-use: addu $8 (Tnew=1) then beq with Tuse=0, then again with Tuse=1
    issue(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 1'b1, 2'd1, 2'b00, 1'b0);
    issue(1'b0, 5'd8, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'b00, 1'b0);
    check("alu_use_tuse0", int'(bus.STALL), 1);
    issue(1'b0, 5'd8, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'b00, 1'b0);
    check("alu_use_tuse0_release", int'(bus.STALL), 0);
    nop(3);
    issue(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 1'b1, 2'd1, 2'b00, 1'b0);
    issue(1'b0, 5'd0, 2'd3, 5'd8, 2'd1, 5'd0, 1'b0, 2'd0, 2'b00, 1'b0);
    check("alu_use_tuse1", int'(bus.STALL), 0);
    nop(3);

    // $0 never hazards; unused operand never hazards
    issue(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b1, 2'd2, 2'b00, 1'b0);
    issue(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'b00, 1'b0);
    check("zero_reg", int'(bus.STALL), 0);
    nop(3);
    issue(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 1'b1, 2'd2, 2'b00, 1'b0);
    issue(1'b0, 5'd0, 2'd3, 5'd5, 2'd3, 5'd0, 1'b0, 2'd0, 2'b00, 1'b0);
    check("unused_rt", int'(bus.STALL), 0);
    nop(3);

    // mult then mflo: 6 stall cycles, 5 busy cycles
    issue(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 2'b01, 1'b1);
    check("mult_issue", int'(bus.STALL), 0);
    issue(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 1'b1, 2'd1, 2'b00, 1'b1);
    n_stall = 0; n_busy = 0; k = 0;
    while (bus.STALL && k < 30) begin
      n_stall++;
      n_busy += int'(bus.MD_BUSY);
      issue(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 1'b1, 2'd1, 2'b00, 1'b1);
      k++;
    end
    n_busy += int'(bus.MD_BUSY);
    check("mult_release_in_bound", int'(bus.STALL), 0);
    check("mult_stall_cycles", n_stall, 6);
    check("mult_busy_cycles", n_busy, 5);
    nop(2);

    // div then non-MDU addu: no stall, busy for 10 cycles
    issue(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 2'b10, 1'b1);
    issue(1'b0, 5'd1, 2'd1, 5'd2, 2'd1, 5'd9, 1'b1, 2'd1, 2'b00, 1'b0);
    check("div_then_addu", int'(bus.STALL), 0);
    n_busy = int'(bus.MD_BUSY);
    for (int i = 0; i < 14; i++) begin
      nop(1);
      n_busy += int'(bus.MD_BUSY);
    end
    check("div_busy_cycles", n_busy, 10);
    nop(2);

    // Reset on the third busy cycle of a div
    issue(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 2'b10, 1'b1);
    nop(3);
    check("div_busy_before_reset", int'(bus.MD_BUSY), 1);
    issue(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 2'b00, 1'b0);
    issue(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 1'b1, 2'd1, 2'b00, 1'b1);
    check("reset_mid_div_busy", int'(bus.MD_BUSY), 0);
    check("reset_mid_div_stall", int'(bus.STALL), 0);
    nop(2);
    // Reset coinciding with a load-use hazard
    issue(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 1'b1, 2'd2, 2'b00, 1'b0);
    issue(1'b1, 5'd8, 2'd1, 5'd0, 2'd3, 5'd9, 1'b1, 2'd1, 2'b00, 1'b0);
    check("hazard_during_reset", int'(bus.STALL), 1);
    issue(1'b0, 5'd8, 2'd1, 5'd0, 2'd3, 5'd9, 1'b1, 2'd1, 2'b00, 1'b0);
    check("hazard_cleared_by_reset", int'(bus.STALL), 0);
    nop(2);

    // Random traffic on a small register set so dependencies are frequent
    prev_stall = 1'b0;
    rs = 5'd0; rt = 5'd0; a3 = 5'd0; tr = 2'd3; tt = 2'd3; tn = 2'd0; mds = 2'b00;
    we = 1'b0; mdu = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!(prev_stall && $urandom_range(0, 3) != 0)) begin
        rs  = 5'($urandom_range(0, 3));
        rt  = 5'($urandom_range(0, 3));
        tr  = 2'($urandom_range(0, 3));
        tt  = 2'($urandom_range(0, 3));
        a3  = 5'($urandom_range(0, 3));
        we  = 1'($urandom_range(0, 1));
        tn  = 2'($urandom_range(0, 2));
        mds = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        mdu = (mds == 2'b01 || mds == 2'b10) ? 1'b1 : 1'($urandom_range(0, 7) == 0);
      end
      issue(1'($urandom_range(0, 199) == 0), rs, tr, rt, tt, a3, we, tn, mds, mdu);
      prev_stall = bus.STALL;
    end
    nop(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
